div_result_bcd_converter: RTL and testbench



---
 rtl/div_result_bcd_converter.sv | 157 +++++++++++++++
 tb/tb_div_result_bcd_converter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd_converter.sv
// div_result_bcd_converter: converts a divider quotient/remainder pair to
// packed BCD using iterative double-dabble, both operands in parallel.
// One pair per transaction, valid/ready on both sides.
module div_result_bcd_converter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      quation,
  input  logic [WIDTH-1:0]      remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   quo_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic                  busy
);

  localparam int unsigned BCDW = 4 * DIGITS;
  localparam int unsigned CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] quo_bin, rem_bin;
  logic [BCDW-1:0]  quo_acc, rem_acc;

  logic [WIDTH-1:0] quo_bin_n, rem_bin_n;
  logic [BCDW-1:0]  quo_adj, rem_adj;
  logic [BCDW-1:0]  quo_acc_n, rem_acc_n;

  logic accept;
  logic last_shift;

  // Add 3 to every BCD digit that is 5 or more, so the following shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCDW-1:0] add3(input logic [BCDW-1:0] v);
    logic [BCDW-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Ready only while idle and never while reset is asserted.
  assign in_ready   = (state == IDLE) && !rst;
  assign accept     = (state == IDLE) && in_valid;
  assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);

  // One double-dabble step for both operands: correct, then shift {bcd,bin} left.
  always_comb begin
    quo_adj   = add3(quo_acc);
    rem_adj   = add3(rem_acc);
    quo_acc_n = {quo_adj[BCDW-2:0], quo_bin[WIDTH-1]};
    rem_acc_n = {rem_adj[BCDW-2:0], rem_bin[WIDTH-1]};
    quo_bin_n = {quo_bin[WIDTH-2:0], 1'b0};
    rem_bin_n = {rem_bin[WIDTH-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_n == DONE);
      busy      <= (state_n == SHIFT);
    end
  end

  // Shift counter: cleared on accept, advanced once per shift edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + CNTW'(1);
    end
  end

  // Binary shifters and BCD accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_bin <= '0;
      rem_bin <= '0;
      quo_acc <= '0;
      rem_acc <= '0;
    end else if (accept) begin
      quo_bin <= quation;
      rem_bin <= remainder;
      quo_acc <= '0;
      rem_acc <= '0;
    end else if (state == SHIFT) begin
      quo_bin <= quo_bin_n;
      rem_bin <= rem_bin_n;
      quo_acc <= quo_acc_n;
      rem_acc <= rem_acc_n;
    end
  end

  // Result registers: written only by the final shift, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_bcd <= '0;
      rem_bcd <= '0;
    end else if (last_shift) begin
      quo_bcd <= quo_acc_n;
      rem_bcd <= rem_acc_n;
    end
  end

endmodule

// File: tb/tb_div_result_bcd_converter.sv
// Directed testbench for div_result_bcd_converter.
module tb_div_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] quation;
  logic [31:0] remainder;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] quo_bcd;
  logic [39:0] rem_bcd;
  logic        busy;

  int passed = 0;
  int total  = 0;

  div_result_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quation   (quation),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo_bcd   (quo_bcd),
    .rem_bcd   (rem_bcd),
    .busy      (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, wait for the result, check latency and values; leaves block in DONE.
  task automatic run_pair(input logic [31:0] q, input logic [31:0] r,
                          input logic [39:0] eq, input logic [39:0] er,
                          input string name);
    int lat;
    lat = 0;
    quation   = q;
    remainder = r;
    in_valid  = 1'b1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_idle: got %b want 1", name, in_ready);
    else passed++;
    step();
    in_valid  = 1'b0;
    quation   = 32'hDEAD_BEEF;
    remainder = 32'h1234_5678;
    total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    else passed++;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat != 32) $display("FAIL %s latency: got %0d want 32", name, lat);
    else passed++;
    total++;
    if (quo_bcd !== eq) $display("FAIL %s quo_bcd: got %h want %h", name, quo_bcd, eq);
    else passed++;
    total++;
    if (rem_bcd !== er) $display("FAIL %s rem_bcd: got %h want %h", name, rem_bcd, er);
    else passed++;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL %s done_flags: got busy=%b in_ready=%b want 0 0", name, busy, in_ready);
    else passed++;
  endtask

  // Hand the result to the consumer and check return to idle.
  task automatic release_result(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    quation = 32'd0;
    remainder = 32'd0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset_flags: got out_valid=%b busy=%b in_ready=%b want 0 0 0",
               out_valid, busy, in_ready);
    else passed++;
    total++;
    if (quo_bcd !== 40'h0 || rem_bcd !== 40'h0)
      $display("FAIL reset_data: got %h %h want 0 0", quo_bcd, rem_bcd);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_values();
    run_pair(32'd2, 32'd2, 40'h00_0000_0002, 40'h00_0000_0002, "8div3");
    release_result("8div3");
    run_pair(32'd715827882, 32'd2, 40'h07_1582_7882, 40'h00_0000_0002, "2p31div3");
    release_result("2p31div3");
    run_pair(32'hFFFF_FFFF, 32'd0, 40'h42_9496_7295, 40'h00_0000_0000, "allones");
    release_result("allones");
    run_pair(32'd0, 32'd0, 40'h0, 40'h0, "zeros");
    release_result("zeros");
    run_pair(32'd99999, 32'd1000000009, 40'h00_0009_9999, 40'h10_0000_0009, "mixed");
    release_result("mixed");
  endtask

  task automatic test_backpressure();
    bit stable;
    stable = 1'b1;
    run_pair(32'd12345, 32'd678, 40'h00_0001_2345, 40'h00_0000_0678, "bp");
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      quation   = 32'd4242 + 32'(i);
      remainder = 32'd7;
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          quo_bcd !== 40'h00_0001_2345 || rem_bcd !== 40'h00_0000_0678)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (!stable) $display("FAIL bp_hold: got outputs changed during stall want stable");
    else passed++;
    release_result("bp");
    total++;
    if (quo_bcd !== 40'h00_0001_2345 || rem_bcd !== 40'h00_0000_0678)
      $display("FAIL bp_idle_hold: got %h %h want 12345 678", quo_bcd, rem_bcd);
    else passed++;
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    quation   = 32'd77;
    remainder = 32'd5;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || quo_bcd !== 40'h0 || rem_bcd !== 40'h0)
      $display("FAIL abort_cleared: got busy=%b quo=%h rem=%h want 0 0 0", busy, quo_bcd, rem_bcd);
    else passed++;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL abort_no_output: got out_valid=1 want 0");
    else passed++;
    run_pair(32'd1, 32'd0, 40'h1, 40'h0, "after_abort");
    release_result("after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] qs [3];
    logic [31:0] rs [3];
    logic [39:0] eqs [3];
    logic [39:0] ers [3];
    int t_out [3];
    int nin;
    int nout;
    bit acc;
    qs  = '{32'd1, 32'd2, 32'd715827882};
    rs  = '{32'd1, 32'd2, 32'd2};
    eqs = '{40'h1, 40'h2, 40'h07_1582_7882};
    ers = '{40'h1, 40'h2, 40'h2};
    t_out = '{0, 0, 0};
    nin = 0;
    nout = 0;
    quation   = qs[0];
    remainder = rs[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && nout < 3; cyc++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        nin++;
        if (nin < 3) begin
          quation   = qs[nin];
          remainder = rs[nin];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (quo_bcd !== eqs[nout] || rem_bcd !== ers[nout])
          $display("FAIL b2b_result%0d: got %h %h want %h %h",
                   nout, quo_bcd, rem_bcd, eqs[nout], ers[nout]);
        else passed++;
        t_out[nout] = cyc;
        nout++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (nout != 3) $display("FAIL b2b_count: got %0d want 3", nout);
    else passed++;
    total++;
    if (t_out[1] - t_out[0] != 34 || t_out[2] - t_out[1] != 34)
      $display("FAIL b2b_spacing: got %0d %0d want 34 34",
               t_out[1] - t_out[0], t_out[2] - t_out[1]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
